// File: rtl/fifo_rv.sv
// Single-clock valid/ready FIFO with occupancy counter, threshold flags and flush.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_STATUS_EN.
module fifo_rv #(
  parameter int AWIDTH   = 4,
  parameter int DWIDTH   = 32,
  parameter int AF_LEVEL = 2**AWIDTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWIDTH-1:0] out_data_o,
  output logic [AWIDTH:0]   count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o,
  input  logic              err_clr_i
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_CNT = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_CNT    = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0] AE_CNT    = (AWIDTH+1)'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_levels
    $error("fifo_rv: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
  end

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   count;
  logic              push;
  logic              pop;

  assign full_o         = (count == DEPTH_CNT);
  assign empty_o        = (count == '0);
  assign in_ready_o     = !full_o && !flush_i;
  assign out_valid_o    = !empty_o && !flush_i;
  assign push           = in_valid_i && in_ready_o;
  assign pop            = out_valid_o && out_ready_i;
  assign count_o        = count;
  assign almost_full_o  = (count >= AF_CNT);
  assign almost_empty_o = (count <= AE_CNT);
  // First-word fall-through: head entry is read straight from storage.
  assign out_data_o     = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef FIFO_STATUS_EN
  logic ovf;
  logic unf;

  // Clear takes priority over a set in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (err_clr_i) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (in_valid_i && !in_ready_o && !flush_i) begin
        ovf <= 1'b1;
      end
      if (out_ready_i && !out_valid_o && !flush_i) begin
        unf <= 1'b1;
      end
    end
  end

  assign overflow_o  = ovf;
  assign underflow_o = unf;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign overflow_o     = 1'b0;
  assign underflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rv.sv
// Directed bench for fifo_rv: reference model with scoreboard queue, checked every cycle.
// Expectations for the sticky flags follow FIFO_STATUS_EN as compiled.
module tb_fifo_rv;

  localparam int AWIDTH = 4;
  localparam int DWIDTH = 32;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DWIDTH-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DWIDTH-1:0] out_data_o;
  logic [AWIDTH:0]   count_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic              overflow_o;
  logic              underflow_o;
  logic              err_clr_i;

  fifo_rv #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .count_o        (count_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o),
    .err_clr_i      (err_clr_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DWIDTH-1:0] mmem [DEPTH];
  int                mwr, mrd, mcnt;
  bit                movf, munf;
  logic [DWIDTH-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    mwr = 0; mrd = 0; mcnt = 0;
    movf = 1'b0; munf = 1'b0;
    sb.delete();
  endtask

  // One clock: check outputs at negedge against the model, then advance the model at posedge.
  task automatic cycle();
    bit mready, mvalid, mpush, mpop;
    logic [DWIDTH-1:0] exp_head;
    @(negedge clk);
    mready = (mcnt != DEPTH) && !flush_i;
    mvalid = (mcnt != 0) && !flush_i;
    mpush  = in_valid_i && mready;
    mpop   = mvalid && out_ready_i;
    chk("count", 32'(count_o), 32'(mcnt));
    chk("in_ready", 32'(in_ready_o), 32'(mready));
    chk("out_valid", 32'(out_valid_o), 32'(mvalid));
    chk("full", 32'(full_o), 32'(mcnt == DEPTH));
    chk("empty", 32'(empty_o), 32'(mcnt == 0));
    chk("almost_full", 32'(almost_full_o), 32'(mcnt >= DEPTH - 2));
    chk("almost_empty", 32'(almost_empty_o), 32'(mcnt <= 2));
    chk("overflow", 32'(overflow_o), 32'(movf));
    chk("underflow", 32'(underflow_o), 32'(munf));
    chk("out_data", out_data_o, mmem[mrd]);
    if (mpop) begin
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 32'(0), 32'(1));
      end else begin
        exp_head = sb.pop_front();
        chk("pop_data", out_data_o, exp_head);
      end
    end
    @(posedge clk);
`ifdef FIFO_STATUS_EN
    if (err_clr_i) begin
      movf = 1'b0; munf = 1'b0;
    end else begin
      if (in_valid_i && !mready && !flush_i) movf = 1'b1;
      if (out_ready_i && !mvalid && !flush_i) munf = 1'b1;
    end
`endif
    if (flush_i) begin
      mwr = 0; mrd = 0; mcnt = 0;
      sb.delete();
    end else begin
      if (mpush) begin
        mmem[mwr] = in_data_i;
        sb.push_back(in_data_i);
        mwr = (mwr + 1) % DEPTH;
      end
      if (mpop) mrd = (mrd + 1) % DEPTH;
      mcnt = mcnt + (mpush ? 1 : 0) - (mpop ? 1 : 0);
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [DWIDTH-1:0] d, input bit r, input bit f, input bit c);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    err_clr_i   = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0;
    drive(0, '0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Reset state
    cycle();
    chk("reset_out_data", out_data_o, 32'h0);

    // Fill to full with consumer stalled
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h100 + 32'(i), 0, 0, 0);
      cycle();
    end
    chk("filled_count", 32'(count_o), 32'd16);
    chk("filled_full", 32'(full_o), 32'd1);
    // Push attempt while full
    drive(1, 32'h1FF, 0, 0, 0);
    cycle();
    drive(0, '0, 0, 0, 0);
    cycle();

    // Full with both sides active: pop only, then push accepted
    drive(1, 32'h200, 1, 0, 0);
    cycle();
    chk("full_both_count", 32'(count_o), 32'd15);
    drive(1, 32'h201, 1, 0, 0);
    cycle();
    chk("after_full_count", 32'(count_o), 32'd15);

    // Drain everything, then one extra pop on empty
    drive(0, '0, 1, 0, 0);
    while (mcnt > 0) cycle();
    cycle();
    drive(0, '0, 0, 0, 0);
    cycle();
    chk("drained_empty", 32'(empty_o), 32'd1);

    // Clear sticky flags
    drive(0, '0, 0, 0, 1);
    cycle();
    drive(0, '0, 0, 0, 0);
    cycle();
    chk("cleared_ovf", 32'(overflow_o), 32'd0);
    chk("cleared_unf", 32'(underflow_o), 32'd0);

    // Pointer wrap: occupancy 3 with steady push+pop
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(i), 0, 0, 0);
      cycle();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1, $urandom, 1, 0, 0);
      cycle();
    end
    chk("wrap_count", 32'(count_o), 32'd3);

    // Bring occupancy to 9, then flush with push and pop requested
    drive(1, 32'h400, 0, 0, 0);
    while (mcnt < 9) begin
      in_data_i = in_data_i + 1;
      cycle();
    end
    drive(1, 32'h4FF, 1, 1, 0);
    cycle();
    drive(0, '0, 0, 0, 0);
    cycle();
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_empty", 32'(empty_o), 32'd1);
    drive(1, 32'h500, 0, 0, 0);
    cycle();
    drive(0, '0, 1, 0, 0);
    cycle();
    drive(0, '0, 0, 0, 0);
    cycle();

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h600 + 32'(i), 0, 0, 0);
      cycle();
    end
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_empty", 32'(empty_o), 32'd1);
    chk("arst_out_data", out_data_o, 32'h0);
    drive(0, '0, 0, 0, 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    cycle();
    drive(1, 32'h700, 0, 0, 0);
    cycle();
    drive(0, '0, 1, 0, 0);
    cycle();
    drive(0, '0, 0, 0, 0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
